// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, framing status.
// Optional even parity bit when UART_RX_PARITY_EN is defined.
module uart_rx #(
  parameter int CLKS_PER_BIT = 436,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       done,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID  = CW'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t        state;
  logic          sync1;
  logic          line_s;
  logic          prev_s;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

`ifdef UART_RX_PARITY_EN
  logic par_bad;
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
  localparam logic   par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sync1     <= 1'b1;
      line_s    <= 1'b1;
      prev_s    <= 1'b1;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      data_out  <= '0;
      done      <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      sync1  <= data_in;
      line_s <= sync1;
      prev_s <= line_s;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          // Falling edge only; a line stuck low never re-arms.
          if (prev_s && !line_s) begin
            state <= START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt == MID) begin
            if (line_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state   <= DATA;
              cnt     <= '0;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            shift   <= {line_s, shift[7:1]};
            cnt     <= '0;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7)
              state <= AFTER_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == LAST) begin
            par_bad <= (^shift) ^ line_s;
            cnt     <= '0;
            state   <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`endif
        STOP: begin
          if (cnt == LAST) begin
            done      <= 1'b1;
            frame_err <= ~line_s;
`ifdef UART_RX_PARITY_EN
            parity_err <= par_bad;
`endif
            if (line_s && !par_bad)
              data_out <= shift;
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with CLKS_PER_BIT=16.
// Build with UART_RX_PARITY_EN to add the parity frames.
module tb_uart_rx;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME = 11 * CPB;
`else
  localparam int FRAME = 10 * CPB;
`endif
  // start edge E -> stop-sample edge: 2 sync + half bit + (FRAME/CPB-1) bits
  localparam int DONE_OFS = 2 + CPB / 2 + FRAME - CPB;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       data_in = 1'b1;
  logic [7:0] data_out;
  logic       done;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int total = 0;
  int bad = 0;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clock     (clock),
    .reset     (reset),
    .data_in   (data_in),
    .data_out  (data_out),
    .done      (done),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input logic pflip, output int e);
    e = cyc + 1;
    data_in = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      data_in = b[i];
      wait_cyc(CPB);
    end
`ifdef UART_RX_PARITY_EN
    data_in = (^b) ^ pflip;
    wait_cyc(CPB);
`endif
    data_in = stop;
    wait_cyc(CPB);
  endtask

  int e0, e1, n0;

  initial begin
    wait_cyc(3);
    chk("rst_data", 32'(data_out), 32'h00);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_perr", 32'(parity_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    wait_cyc(10);

    // single good frame
    n0 = done_cnt;
    send_frame(8'hA5, 1'b1, 1'b0, e0);
    chk("a5_cnt", 32'(done_cnt - n0), 32'd1);
    chk("a5_time", 32'(done_cyc), 32'(e0 + DONE_OFS));
    chk("a5_data", 32'(data_out), 32'hA5);
    chk("a5_ferr", 32'(frame_err), 32'd0);
    chk("a5_busy", 32'(busy), 32'd0);
    chk("a5_done", 32'(done), 32'd0);
    wait_cyc(5);

    // back-to-back, no idle gap
    n0 = done_cnt;
    send_frame(8'h00, 1'b1, 1'b0, e0);
    chk("b2b0_data", 32'(data_out), 32'h00);
    chk("b2b0_time", 32'(done_cyc), 32'(e0 + DONE_OFS));
    e1 = done_cyc;
    send_frame(8'hFF, 1'b1, 1'b0, e0);
    chk("b2b1_data", 32'(data_out), 32'hFF);
    chk("b2b_gap", 32'(done_cyc - e1), 32'(FRAME));
    chk("b2b_cnt", 32'(done_cnt - n0), 32'd2);
    wait_cyc(5);

    // 4-clock glitch: false start
    n0 = done_cnt;
    data_in = 1'b0;
    wait_cyc(4);
    data_in = 1'b1;
    wait_cyc(2);
    chk("gl_busy_hi", 32'(busy), 32'd1);
    wait_cyc(30);
    chk("gl_busy_lo", 32'(busy), 32'd0);
    chk("gl_cnt", 32'(done_cnt - n0), 32'd0);
    chk("gl_data", 32'(data_out), 32'hFF);

    // bad stop bit, then line held low
    n0 = done_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, e0);
    chk("fe_cnt", 32'(done_cnt - n0), 32'd1);
    chk("fe_ferr", 32'(frame_err), 32'd1);
    chk("fe_data", 32'(data_out), 32'hFF);
    wait_cyc(50);
    chk("low_busy", 32'(busy), 32'd0);
    chk("low_cnt", 32'(done_cnt - n0), 32'd1);
    chk("low_ferr", 32'(frame_err), 32'd1);
    data_in = 1'b1;
    wait_cyc(20);

    // reset in data bit 4 of 0x81
    n0 = done_cnt;
    data_in = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 4; i++) begin
      data_in = (i == 0);
      wait_cyc(CPB);
    end
    data_in = 1'b0;
    wait_cyc(8);
    chk("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_data", 32'(data_out), 32'h00);
    chk("ar_ferr", 32'(frame_err), 32'd0);
    chk("ar_done", 32'(done), 32'd0);
    wait_cyc(4);
    data_in = 1'b1;
    wait_cyc(4);
    reset = 1'b0;
    wait_cyc(20);
    chk("ar_cnt", 32'(done_cnt - n0), 32'd0);
    chk("ar_idle", 32'(busy), 32'd0);
    send_frame(8'h81, 1'b1, 1'b0, e0);
    chk("r81_cnt", 32'(done_cnt - n0), 32'd1);
    chk("r81_time", 32'(done_cyc), 32'(e0 + DONE_OFS));
    chk("r81_data", 32'(data_out), 32'h81);
    chk("r81_ferr", 32'(frame_err), 32'd0);
    chk("r81_perr", 32'(parity_err), 32'd0);
    wait_cyc(5);

`ifdef UART_RX_PARITY_EN
    n0 = done_cnt;
    send_frame(8'h07, 1'b1, 1'b0, e0);
    chk("p07_perr", 32'(parity_err), 32'd0);
    chk("p07_data", 32'(data_out), 32'h07);
    wait_cyc(5);
    send_frame(8'h3C, 1'b1, 1'b0, e0);
    chk("p3c_data", 32'(data_out), 32'h3C);
    wait_cyc(5);
    send_frame(8'h07, 1'b1, 1'b1, e0);
    chk("pbad_cnt", 32'(done_cnt - n0), 32'd3);
    chk("pbad_perr", 32'(parity_err), 32'd1);
    chk("pbad_ferr", 32'(frame_err), 32'd0);
    chk("pbad_data", 32'(data_out), 32'h3C);
    wait_cyc(5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
